// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side character FIFO sitting between a UART receiver and a register
// interface. Characters arrive on rx_done strobes and are popped with rd_en.
// A pop produces registered rd_data with a one-cycle rd_valid pulse. Status
// flags are decoded from the occupancy counter. A sticky overrun flag records
// characters dropped because the FIFO was full.
//
// Ports:
//   clk      in   rising-edge clock
//   rstn     in   asynchronous active-low reset
//   data_i   in   [DATA_WIDTH] received character
//   rx_done  in   one-cycle write strobe (data_i valid in the same cycle)
//   rd_en    in   read request
//   flush    in   synchronous clear of contents and overrun
//   ovr_clr  in   clears the sticky overrun flag
//   rd_data  out  [DATA_WIDTH] registered read data, held between reads
//   rd_valid out  one-cycle pulse, rd_data holds a popped character
//   empty    out  count == 0
//   full     out  count == DEPTH
//   count    out  [ADDR_WIDTH+1] stored entries
//   overrun  out  sticky, a character was dropped
//   irq      out  level, count >= THRESH
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int THRESH     = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rx_done,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  ovr_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overrun,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   THRESH_C = (ADDR_WIDTH+1)'(THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overrun_q, overrun_d;

  logic empty_w, full_w;
  logic rd_acc, wr_acc, drop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // flush discards any coincident traffic. A read makes room in the same
  // cycle, so a write on a full FIFO is accepted if the read is.
  assign rd_acc = rd_en && !empty_w && !flush;
  assign wr_acc = rx_done && (!full_w || rd_acc) && !flush;
  assign drop   = rx_done && full_w && !rd_acc && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overrun_d  = overrun_q;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // A new drop takes priority over a coincident clear.
      if (drop) begin
        overrun_d = 1'b1;
      end else if (ovr_clr) begin
        overrun_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage is not reset; only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign irq      = (count_q >= THRESH_C);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (DEPTH=16, THRESH=8, DATA_WIDTH=8).
// Inputs change 1 time unit after the rising edge; outputs are checked at
// that same point, i.e. after the edge that consumed the previous inputs.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rstn;
  logic [7:0] data_i;
  logic       rx_done;
  logic       rd_en;
  logic       flush;
  logic       ovr_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (16),
    .THRESH    (8)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .data_i  (data_i),
    .rx_done (rx_done),
    .rd_en   (rd_en),
    .flush   (flush),
    .ovr_clr (ovr_clr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rx;
    logic [7:0] d;
    logic       rd;
    logic       fl;
    logic       oc;
    logic       ev;
    logic [7:0] ed;
    int         ecnt;
    logic       eovr;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Full output check; empty/full/irq follow from the expected count.
  task automatic expect_state(input string tag, input logic ev, input logic [7:0] ed,
                              input int ecnt, input logic eovr);
    chk({tag, ".rd_valid"}, int'(rd_valid), int'(ev));
    chk({tag, ".rd_data"},  int'(rd_data),  int'(ed));
    chk({tag, ".count"},    int'(count),    ecnt);
    chk({tag, ".empty"},    int'(empty),    (ecnt == 0) ? 1 : 0);
    chk({tag, ".full"},     int'(full),     (ecnt == 16) ? 1 : 0);
    chk({tag, ".irq"},      int'(irq),      (ecnt >= 8) ? 1 : 0);
    chk({tag, ".overrun"},  int'(overrun),  int'(eovr));
  endtask

  task automatic step(input logic rx, input logic [7:0] d, input logic rd,
                      input logic fl, input logic oc);
    rx_done = rx;
    data_i  = d;
    rd_en   = rd;
    flush   = fl;
    ovr_clr = oc;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    ovr_clr = 1'b0;
    data_i  = 8'h00;
  endtask

  logic [7:0] last_rd;

  initial begin
    rstn = 1'b0; data_i = 8'h00; rx_done = 1'b0; rd_en = 1'b0;
    flush = 1'b0; ovr_clr = 1'b0;

    //            rx    d      rd    fl    oc    ev    ed     cnt  ovr
    vecs[0] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0}; // write 5A
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 0, 1'b0}; // pop 5A
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 0, 1'b0}; // data held
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 0, 1'b0}; // read on empty
    vecs[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1, 1'b0}; // wr+rd empty
    vecs[5] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1, 1'b0}; // wr+rd count 1
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 0, 1'b0}; // pop 44
    vecs[7] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 0, 1'b0}; // flush eats write
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 0, 1'b0}; // nothing stored
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 0, 1'b0}; // ovr_clr idle

    repeat (2) @(posedge clk);
    #1;
    expect_state("reset", 1'b0, 8'h00, 0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rx, vecs[i].d, vecs[i].rd, vecs[i].fl, vecs[i].oc);
      expect_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ecnt, vecs[i].eovr);
    end
    last_rd = 8'h44;

    // Fill, partial drain, refill across the wrap point, full drain.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      expect_state($sformatf("fill%0d", i), 1'b0, last_rd, i + 1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      last_rd = 8'(i);
      expect_state($sformatf("rd4_%0d", i), 1'b1, last_rd, 15 - i, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      expect_state($sformatf("wrap%0d", i), 1'b0, last_rd, 13 + i, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      last_rd = 8'(4 + i);
      expect_state($sformatf("drain%0d", i), 1'b1, last_rd, 15 - i, 1'b0);
    end

    // Overrun behaviour.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    end
    expect_state("ovr_full", 1'b0, last_rd, 16, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    expect_state("ovr_drop", 1'b0, last_rd, 16, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_state("ovr_sticky", 1'b0, last_rd, 16, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_state("ovr_clr", 1'b0, last_rd, 16, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    expect_state("ovr_clr_drop", 1'b0, last_rd, 16, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_state("ovr_clr2", 1'b0, last_rd, 16, 1'b0);
    step(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    last_rd = 8'h20;
    expect_state("full_wr_rd", 1'b1, last_rd, 16, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
    expect_state("ovr_drop2", 1'b0, last_rd, 16, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      last_rd = (i < 15) ? 8'(8'h21 + i) : 8'hCC;
      expect_state($sformatf("ovr_drain%0d", i), 1'b1, last_rd, 15 - i, 1'b1);
    end

    // Flush with stored entries and overrun set; coincident traffic discarded.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    end
    expect_state("pre_flush", 1'b0, last_rd, 5, 1'b1);
    step(1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
    expect_state("flush", 1'b0, last_rd, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    expect_state("post_flush_rd", 1'b0, last_rd, 0, 1'b0);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    end
    expect_state("pre_rst", 1'b0, last_rd, 3, 1'b0);
    rx_done = 1'b1;
    data_i  = 8'h73;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    rx_done = 1'b0;
    data_i  = 8'h00;
    last_rd = 8'h00;
    expect_state("mid_rst", 1'b0, last_rd, 0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    expect_state("rst_wr", 1'b0, last_rd, 1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    last_rd = 8'h99;
    expect_state("rst_rd", 1'b1, last_rd, 0, 1'b0);

    // Threshold: irq follows count >= 8.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
      expect_state($sformatf("thr%0d", i), 1'b0, last_rd, i + 1, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    last_rd = 8'hA0;
    expect_state("thr_rd", 1'b1, last_rd, 7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one received character.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries, power of two and >= 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), pointer width.
REQ-004 SHALL have parameter THRESH, default 8, fill level at which irq asserts, range 1..DEPTH.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  clock, all logic on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 data_i  input  DATA_WIDTH  received character from the UART receiver.
REQ-008 rx_done  input  1  one-cycle write strobe, character valid on data_i in the same cycle.
REQ-009 rd_en  input  1  read request from the register interface.
REQ-010 flush  input  1  synchronous clear of contents and overrun flag.
REQ-011 ovr_clr  input  1  clears the sticky overrun flag.
REQ-012 rd_data  output  DATA_WIDTH  registered read data.
REQ-013 rd_valid  output  1  one-cycle pulse, rd_data holds a popped character.
REQ-014 empty  output  1  count == 0.
REQ-015 full  output  1  count == DEPTH.
REQ-016 count  output  ADDR_WIDTH+1  current number of stored entries.
REQ-017 overrun  output  1  sticky, a character was dropped.
REQ-018 irq  output  1  level, count >= THRESH.

Function
REQ-019 Storage SHALL be a circular buffer with write pointer, read pointer (ADDR_WIDTH bits each, wrapping DEPTH-1 -> 0) and a separate occupancy counter.
REQ-020 Write accepted when rx_done=1 and (full=0 or a read is accepted in the same cycle): data_i stored at write pointer, pointer incremented.
REQ-021 Read accepted when rd_en=1 and empty=0: entry at read pointer loaded into rd_data on the next edge, rd_valid=1 for exactly that following cycle, pointer incremented.
REQ-022 rd_en with empty=1 SHALL be ignored: rd_valid stays 0, rd_data unchanged, no pointer movement.
REQ-023 rd_data SHALL hold its last value when no read is accepted.
REQ-024 Simultaneous accepted read and write: count unchanged, both pointers advance.
REQ-025 Simultaneous write and read when empty: write accepted, read ignored, count becomes 1.
REQ-026 Simultaneous write and read when full: both accepted, no overrun, full stays 1.
REQ-027 rx_done when full and no accepted read: character dropped, contents and pointers unchanged, overrun set to 1 on next edge.
REQ-028 overrun SHALL stay 1 until ovr_clr=1 or flush=1; if a new drop occurs in the same cycle as ovr_clr, overrun remains 1.
REQ-029 flush=1 SHALL on the next edge zero both pointers, count and overrun; a write or read in the same cycle SHALL be discarded; rd_valid=0; rd_data unchanged.
REQ-030 Write-to-read latency: a character written at edge N SHALL be readable by rd_en sampled at edge N+1 (empty deasserts after edge N).
REQ-031 empty, full, irq SHALL be combinational decodes of the registered count, no additional delay.
REQ-032 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-033 rstn=0 SHALL asynchronously clear pointers, count, rd_data (all zeros), rd_valid, overrun; outputs: empty=1, full=0, irq=0, count=0.
REQ-034 Reset asserted mid-operation SHALL discard all stored characters; first rx_done after release SHALL be stored at entry 0.
REQ-035 Storage array contents need not be reset.

Verification
REQ-036 Single write/read: rx_done with data_i=0x5A, rd_en next cycle -> rd_valid pulse one cycle later, rd_data=0x5A, empty=1 after.
REQ-037 Fill and wrap: DEPTH=16, write 0x00..0x0F -> full=1, count=16; read 4, write 0x10..0x13 -> read-out order 0x04..0x13, no overrun.
REQ-038 Overrun: full FIFO, rx_done with 0xAA -> overrun=1, 0xAA never read; ovr_clr -> overrun=0; ovr_clr coincident with second drop -> overrun stays 1.
REQ-039 Simultaneous ops: full + rx_done + rd_en -> count stays 16, overrun=0; empty + rx_done + rd_en -> rd_valid=0, count=1.
REQ-040 Threshold: THRESH=8, write 7 -> irq=0; 8th write -> irq=1 after that edge; one read -> irq=0.
REQ-041 Flush/reset: 5 entries stored, flush -> count=0, empty=1, overrun=0; repeat with rstn pulse mid-write burst -> count=0, next write lands in entry 0.
